// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer and its consumers.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK,
    HOLD
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
  localparam int         MAX_PAYLOAD_DEF  = 16;
  localparam int         TIMEOUT_CLKS_DEF = 5400;

  // Command ids understood by acquisition control.
  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_STATUS   = 8'h05;
  localparam logic [7:0] CMD_START    = 8'h10;
  localparam logic [7:0] CMD_STOP     = 8'h11;
  localparam logic [7:0] CMD_SET_RATE = 8'h20;
  localparam logic [7:0] CMD_SET_GAIN = 8'h21;

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: one write port, one registered read port, writes blocked
// while a command is being held for the consumer.
module uart_cmd_buf
  import uart_cmd_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF,
  parameter int LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          wr_en,
  input  logic          hold,
  input  logic [LW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [LW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  logic [7:0] mem [MAX_PAYLOAD];
  logic       wr_ok;

  assign wr_ok = wr_en && !hold && (wr_addr < LW'(MAX_PAYLOAD));

  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  // Out-of-range reads keep the previous value; the consumer must not rely on them.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rd_data <= '0;
    end else if (rd_addr < LW'(MAX_PAYLOAD)) begin
      rd_data <= mem[rd_addr[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames SYNC, CMD, LEN, payload, CHK commands from UART bytes and holds each good
// command for a valid/ready consumer. Inter-byte timeout enabled by UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         MAX_PAYLOAD  = MAX_PAYLOAD_DEF,
`ifdef UART_CMD_TIMEOUT_EN
  parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
`endif
  parameter int         LW           = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  output logic          o_Cmd_Valid,
  input  logic          i_Cmd_Ready,
  output logic [7:0]    o_Cmd_Id,
  output logic [LW-1:0] o_Cmd_Len,
  input  logic [LW-1:0] i_Pl_Addr,
  output logic [7:0]    o_Pl_Data,
  output logic          o_Err_Chk,
  output logic          o_Err_Len,
  output logic          o_Err_Timeout,
  output logic          o_Overrun,
  output logic          o_Busy
);

  state_t        state;
  logic [7:0]    frame_id;
  logic [7:0]    xor_acc;
  logic [LW-1:0] frame_len;
  logic [LW-1:0] pl_idx;
  logic          buf_we;

  assign buf_we = i_Rx_DV && (state == PAYLOAD);

  uart_cmd_buf #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .LW         (LW)
  ) u_buf (
    .i_Clock(i_Clock),
    .i_Rst_L(i_Rst_L),
    .wr_en  (buf_we),
    .hold   (state == HOLD),
    .wr_addr(pl_idx),
    .wr_data(i_Rx_Byte),
    .rd_addr(i_Pl_Addr),
    .rd_data(o_Pl_Data)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);

  // idle_cnt holds the number of clocks elapsed since the last strobe clock.
  logic [TW-1:0] idle_cnt;
  logic          in_frame;
  logic          timeout_hit;

  assign in_frame    = (state == CMD) || (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign timeout_hit = in_frame && !i_Rx_DV && (idle_cnt == TW'(TIMEOUT_CLKS - 2));
`else
  assign o_Err_Timeout = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      frame_id    <= '0;
      frame_len   <= '0;
      pl_idx      <= '0;
      xor_acc     <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd_Id    <= '0;
      o_Cmd_Len   <= '0;
      o_Err_Chk   <= 1'b0;
      o_Err_Len   <= 1'b0;
      o_Overrun   <= 1'b0;
      o_Busy      <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      o_Err_Timeout <= 1'b0;
      idle_cnt      <= '0;
`endif
    end else begin
      o_Err_Chk <= 1'b0;
      o_Err_Len <= 1'b0;
      o_Overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
            state   <= CMD;
            o_Busy  <= 1'b1;
            xor_acc <= '0;
          end
        end
        CMD: begin
          if (i_Rx_DV) begin
            frame_id <= i_Rx_Byte;
            xor_acc  <= xor_acc ^ i_Rx_Byte;
            state    <= LEN;
          end
        end
        LEN: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte > 8'(MAX_PAYLOAD)) begin
              o_Err_Len <= 1'b1;
              o_Busy    <= 1'b0;
              state     <= IDLE;
            end else begin
              frame_len <= i_Rx_Byte[LW-1:0];
              pl_idx    <= '0;
              xor_acc   <= xor_acc ^ i_Rx_Byte;
              state     <= (i_Rx_Byte == 8'd0) ? CHK : PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (i_Rx_DV) begin
            xor_acc <= xor_acc ^ i_Rx_Byte;
            pl_idx  <= pl_idx + LW'(1);
            if (pl_idx == frame_len - LW'(1)) state <= CHK;
          end
        end
        CHK: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == xor_acc) begin
              o_Cmd_Valid <= 1'b1;
              o_Cmd_Id    <= frame_id;
              o_Cmd_Len   <= frame_len;
              state       <= HOLD;
            end else begin
              o_Err_Chk <= 1'b1;
              o_Busy    <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        HOLD: begin
          // On acceptance the same-cycle byte is treated as an IDLE byte.
          if (i_Cmd_Ready) begin
            o_Cmd_Valid <= 1'b0;
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
              state   <= CMD;
              xor_acc <= '0;
            end else begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end
          end else if (i_Rx_DV) begin
            o_Overrun <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          o_Busy      <= 1'b0;
          o_Cmd_Valid <= 1'b0;
        end
      endcase

`ifdef UART_CMD_TIMEOUT_EN
      o_Err_Timeout <= 1'b0;
      if (i_Rx_DV) begin
        idle_cnt <= TW'(1);
      end else if (timeout_hit) begin
        o_Err_Timeout <= 1'b1;
        o_Busy        <= 1'b0;
        state         <= IDLE;
      end else if (in_frame) begin
        idle_cnt <= idle_cnt + TW'(1);
      end
`endif
    end
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command framer that sits directly behind the UART receiver in the VDAS firmware. It consumes the receiver's one-cycle data-valid pulses and assembles framed commands of the form SYNC, CMD, LEN, payload[LEN], CHK. It checks the XOR checksum and presents each good command to the acquisition control logic with a valid/ready handshake. The payload is held in a small buffer that the consumer reads by address.

## Interface
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_PAYLOAD, 16: maximum payload bytes; LEN above this is an error.
- TIMEOUT_CLKS, 5400: maximum idle clocks between bytes inside a frame.
- LW, $clog2(MAX_PAYLOAD+1): payload length/address width (derived).
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  one-cycle byte strobe from the UART receiver.
- i_Rx_Byte  in  8  received byte, valid with i_Rx_DV.
- o_Cmd_Valid  out  1  command available; held until accepted.
- i_Cmd_Ready  in  1  consumer accepts the command.
- o_Cmd_Id  out  8  CMD byte of the held frame.
- o_Cmd_Len  out  LW  payload length of the held frame.
- i_Pl_Addr  in  LW  payload read address.
- o_Pl_Data  out  8  payload byte at i_Pl_Addr, registered.
- o_Err_Chk  out  1  one-cycle pulse on checksum mismatch.
- o_Err_Len  out  1  one-cycle pulse when LEN > MAX_PAYLOAD.
- o_Err_Timeout  out  1  one-cycle pulse on inter-byte timeout.
- o_Overrun  out  1  one-cycle pulse when a byte is dropped while a command is held.
- o_Busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: hunt for SYNC_BYTE; all other bytes are ignored.
  - CMD: capture the CMD byte.
  - LEN: capture the LEN byte.
  - PAYLOAD: store bytes into buffer[0..LEN-1].
  - CHK: compare the received byte against the running XOR.
  - HOLD: present the command until accepted.
- Transitions occur only on i_Rx_DV, except for timeout and handshake.
  - IDLE→CMD when the byte equals SYNC_BYTE.
  - CMD→LEN.
  - LEN→PAYLOAD when 0 < LEN ≤ MAX_PAYLOAD. LEN→CHK when LEN = 0. LEN→IDLE with o_Err_Len when LEN > MAX_PAYLOAD.
  - PAYLOAD→CHK after byte index LEN-1.
  - CHK→HOLD on match. CHK→IDLE with o_Err_Chk on mismatch.
- Checksum: 8-bit XOR of CMD, LEN and all payload bytes. SYNC and CHK are excluded. The running XOR is cleared on entry to CMD.
- HOLD: o_Cmd_Valid=1, and o_Cmd_Id/o_Cmd_Len are stable. The buffer is write-protected. Any i_Rx_DV while i_Cmd_Ready=0 is dropped and pulses o_Overrun.
- Handshake: when o_Cmd_Valid & i_Cmd_Ready, the state returns to IDLE on the next edge. An i_Rx_DV in that same cycle is processed as an IDLE byte (SYNC hunt) and is not an overrun.
- Timeout: an inter-byte counter resets on every i_Rx_DV and runs only in CMD, LEN, PAYLOAD and CHK. When it reaches TIMEOUT_CLKS-1 with no byte arriving, the block pulses o_Err_Timeout and returns to IDLE. An i_Rx_DV in that same cycle wins; there is no timeout.
- Reset, including mid-frame: state IDLE, counters and XOR cleared, all outputs 0. Buffer contents are don't-care.

## Timing
- Each byte is registered on the edge after its i_Rx_DV. o_Cmd_Valid rises 1 clock after the i_Rx_DV of the CHK byte.
- Error pulses are asserted 1 clock after the offending i_Rx_DV, or on the timeout edge, and last exactly 1 cycle.
- o_Pl_Data = buffer[i_Pl_Addr], with a latency of 1 clock. It is valid throughout HOLD. Addresses ≥ o_Cmd_Len return unspecified data.
- i_Rx_DV pulses are at least 2 clocks apart; back-to-back strobes are not supported.
- o_Cmd_Id and o_Cmd_Len retain their last values after acceptance.

## Configuration
- UART_CMD_TIMEOUT_EN:
  - Defined: the inter-byte timeout counter and o_Err_Timeout are implemented as described.
  - Undefined: the counter is removed and o_Err_Timeout is tied to 0. A partial frame then waits indefinitely and is recovered only by reset or by completing the frame.

## Structure
- Shared package uart_cmd_pkg:
  - state enum (IDLE, CMD, LEN, PAYLOAD, CHK, HOLD);
  - default SYNC_BYTE;
  - CMD id constants used by acquisition control.
- Sub-module uart_cmd_buf: MAX_PAYLOAD x 8 buffer with one write port, one registered read port and a write enable gated off in HOLD.
- Parser FSM, XOR accumulator and timeout counter live in uart_cmd_parser.

## Test plan
- Good frame: bytes 00, FF, A5, 10, 02, 11, 22, 21 → o_Cmd_Valid with Id=10 and Len=2. Reading addresses 0 and 1 gives 11 and 22 one clock later. No error pulses; the leading 00 and FF are ignored.
- Bad checksum: A5, 10, 02, 11, 22, 20 → o_Err_Chk pulses once, no o_Cmd_Valid, o_Busy=0 afterwards.
- Zero length and length overflow: A5, 05, 00, 05 → Id=05, Len=0 accepted. A5, 01, 11 with MAX_PAYLOAD=16 → o_Err_Len pulses and the parser returns to IDLE.
- Timeout: A5, 10, then silence → o_Err_Timeout pulses exactly TIMEOUT_CLKS-1 clocks after the 10 strobe. A following A5 frame parses normally. With the macro undefined, no pulse occurs.
- Backpressure: i_Cmd_Ready=0 while a second frame arrives → o_Overrun pulses per byte and the held Id and payload are unchanged. Raising i_Cmd_Ready coincident with an A5 strobe → the parser enters CMD.
- Mid-frame reset: assert i_Rst_L=0 during PAYLOAD → all outputs 0 and state IDLE. A complete frame after release parses correctly.
